// File: rtl/serial_uart_bridge.sv
// CPU-facing serial responder: bytes written by the CPU go out on an 8N1 UART TX line,
// and bytes arriving on the RX line are collected in a small show-ahead FIFO for the CPU.
module serial_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned RX_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_wren_in,
  input  logic       cpu_rden_in,
  output logic [7:0] cpu_data_out,
  output logic       cpu_valid_out,
  output logic       cpu_ready_out,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       rx_overrun_out
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // TX path state
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    hold_data_q, hold_data_d;

  // RX path state
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_ferr_q, rx_ferr_d;

  // RX FIFO state
  logic [7:0]    fifo_mem_q [RX_DEPTH];
  logic [7:0]    fifo_mem_d [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;

  logic tx_accept;
  logic tx_load;
  logic rx_push;
  logic fifo_full;
  logic fifo_pop;
  logic push_ok;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    tx_load     = 1'b0;

    tx_accept = cpu_wren_in & ~hold_full_q;
    if (tx_accept) begin
      hold_full_d = 1'b1;
      hold_data_d = cpu_data_in;
    end

    case (tx_state_q)
      S_IDLE: begin
        if (hold_full_q) tx_load = 1'b1;
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else tx_bit_d = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (hold_full_q) tx_load = 1'b1;
          else tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
    endcase

    // A load only happens with the holding register full, so it never collides with an accept.
    if (tx_load) begin
      tx_state_d  = S_START;
      tx_cnt_d    = '0;
      tx_shift_d  = hold_data_q;
      hold_full_d = 1'b0;
    end

    // Line level is registered from the current state, so it trails the state by one cycle.
    case (tx_state_q)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_shift_q[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_meta_d  = uart_rx_in;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    rx_push    = 1'b0;

    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == BIT_HALF) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (rx_ferr_q) begin
          if (rx_sync_q) begin
            rx_ferr_d  = 1'b0;
            rx_state_d = S_IDLE;
          end
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_push    = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overrun_d  = overrun_q;

    fifo_full = (count_q == FIFO_FULL);
    fifo_pop  = cpu_rden_in && (count_q != '0);
    // When full, a simultaneous pop frees the head slot, which is where wr_ptr points.
    push_ok   = rx_push && (!fifo_full || fifo_pop);

    if (rx_push && fifo_full && !fifo_pop) overrun_d = 1'b1;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW + 1)'(push_ok) - (AW + 1)'(fifo_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_line_q   <= 1'b1;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_ferr_q   <= 1'b0;
      fifo_mem_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_line_q   <= tx_line_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_ferr_q   <= rx_ferr_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign uart_tx_out    = tx_line_q;
  assign cpu_ready_out  = ~hold_full_q;
  assign cpu_valid_out  = (count_q != '0);
  assign cpu_data_out   = (count_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;
  assign rx_overrun_out = overrun_q;

endmodule
